// File: rtl/top_xor_exec_if.sv
// Producer/consumer bus of the XOR execution engine: input FIFO push side and output FIFO pop side.
// master = producer/consumer (drives push, data, pop); slave = engine (drives full/ready status and result).
// No storage here; all timing belongs to the engine.
interface top_xor_exec_if #(
    parameter int DW = 8
);
    logic          ififo_push;
    logic [DW-1:0] idata;
    logic          ififo_not_full;
    logic          ofifo_pop;
    logic          ofifo_rdy;
    logic [DW-1:0] odata;

    modport master (
        output ififo_push, idata, ofifo_pop,
        input  ififo_not_full, ofifo_rdy, odata
    );

    modport slave (
        input  ififo_push, idata, ofifo_pop,
        output ififo_not_full, ofifo_rdy, odata
    );
endinterface

// File: rtl/top_xor_exec.sv
// Byte-stream XOR engine: parses header+payload packets from an input FIFO, writes the payload XOR per packet to an output FIFO.
// Latency: header written at edge t0, payload back-to-back at t1..tL -> result at FIFO head after edge t(L+2).
// Backpressure: pushes dropped while input FIFO full; FSM stalls in WR while output FIFO full. Macro XOREXEC_PWR_ISO_EN adds pwr_on reset/isolation.
module top_xor_exec #(
    parameter int DW          = 8,
    parameter int IFIFO_DEPTH = 16,
    parameter int OFIFO_DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    input logic           pwr_on,
    top_xor_exec_if.slave bus
);
    localparam int IAW = $clog2(IFIFO_DEPTH);
    localparam int OAW = $clog2(OFIFO_DEPTH);
    localparam int ICW = IAW + 1;
    localparam int OCW = OAW + 1;
    localparam logic [ICW-1:0] IFULL = ICW'(IFIFO_DEPTH);
    localparam logic [OCW-1:0] OFULL = OCW'(OFIFO_DEPTH);

    typedef enum logic [1:0] {
        HDR = 2'd0,
        PAY = 2'd1,
        WR  = 2'd2
    } state_t;

    // clr wipes every piece of state; pwr_ok gates the outputs (isolation clamp)
    logic clr;
    logic pwr_ok;
`ifdef XOREXEC_PWR_ISO_EN
    assign clr    = rst | ~pwr_on;
    assign pwr_ok = pwr_on;
`else
    logic unused_pwr;
    assign clr        = rst;
    assign pwr_ok     = 1'b1;
    assign unused_pwr = pwr_on;
`endif

    // ---------------- input FIFO ----------------
    logic [DW-1:0]  imem [IFIFO_DEPTH];
    logic [IAW-1:0] iwr_ptr;
    logic [IAW-1:0] ird_ptr;
    logic [ICW-1:0] icount;
    logic           ipush_ok;
    logic           ipop;
    logic [DW-1:0]  ibyte;

    // fullness is judged on the current count, so a push while full is lost even if the FSM pops this cycle
    assign ipush_ok = bus.ififo_push && (icount < IFULL);
    assign ibyte    = imem[ird_ptr];

    // input storage array, no reset needed since reads are gated by the count
    always_ff @(posedge clk) begin
        if (!clr && ipush_ok) begin
            imem[iwr_ptr] <= bus.idata;
        end
    end

    // input FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (clr) begin
            iwr_ptr <= '0;
            ird_ptr <= '0;
            icount  <= '0;
        end else begin
            if (ipush_ok) begin
                iwr_ptr <= iwr_ptr + IAW'(1);
            end
            if (ipop) begin
                ird_ptr <= ird_ptr + IAW'(1);
            end
            icount <= icount + ICW'(ipush_ok) - ICW'(ipop);
        end
    end

    // ---------------- parser FSM ----------------
    state_t        state;
    logic [2:0]    remaining;
    logic [DW-1:0] acc;
    logic [2:0]    hdr_len;
    logic          owr;
    logic [OCW-1:0] ocount;

    // negative/garbage headers (top bit set) carry no payload; bits 6:3 are don't-care
    assign hdr_len = ibyte[DW-1] ? 3'd0 : ibyte[2:0];
    assign ipop    = (state != WR) && (icount != '0);
    assign owr     = (state == WR) && (ocount < OFULL);

    // header decode, payload accumulation and result hand-off to the output FIFO
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= HDR;
            remaining <= '0;
            acc       <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (ipop) begin
                        acc       <= '0;
                        remaining <= hdr_len;
                        state     <= (hdr_len != 3'd0) ? PAY : WR;
                    end
                end
                PAY: begin
                    if (ipop) begin
                        acc       <= acc ^ ibyte;
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) begin
                            state <= WR;
                        end
                    end
                end
                WR: begin
                    if (owr) begin
                        state <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

    // ---------------- output FIFO ----------------
    logic [DW-1:0]  omem [OFIFO_DEPTH];
    logic [OAW-1:0] owr_ptr;
    logic [OAW-1:0] ord_ptr;
    logic           opop;

    // pop on empty is ignored so the consumer may overrun by a cycle safely
    assign opop = bus.ofifo_pop && (ocount != '0);

    // output storage array
    always_ff @(posedge clk) begin
        if (!clr && owr) begin
            omem[owr_ptr] <= acc;
        end
    end

    // output FIFO pointers and occupancy; simultaneous write and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (clr) begin
            owr_ptr <= '0;
            ord_ptr <= '0;
            ocount  <= '0;
        end else begin
            if (owr) begin
                owr_ptr <= owr_ptr + OAW'(1);
            end
            if (opop) begin
                ord_ptr <= ord_ptr + OAW'(1);
            end
            ocount <= ocount + OCW'(owr) - OCW'(opop);
        end
    end

    // status and first-word-fall-through data, all clamped to 0 when the domain is isolated
    assign bus.ififo_not_full = pwr_ok && (icount < IFULL);
    assign bus.ofifo_rdy      = pwr_ok && (ocount != '0);
    assign bus.odata          = (pwr_ok && (ocount != '0)) ? omem[ord_ptr] : '0;

endmodule

// File: tb/tb_top_xor_exec.sv
// Testbench for top_xor_exec: randomized and directed packets, expected XOR results queued on issue.
// A monitor process pops results whenever ofifo_rdy is seen and compares against the queue.
// Power-isolation scenario is compiled in only with XOREXEC_PWR_ISO_EN.
module tb_top_xor_exec;
    logic clk = 1'b0;
    logic rst;
    logic pwr_on;

    always #5 clk = ~clk;

    top_xor_exec_if #(.DW(8)) bus ();

    top_xor_exec #(
        .DW(8),
        .IFIFO_DEPTH(16),
        .OFIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwr_on(pwr_on),
        .bus(bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay_buf[$];
    bit         cons_en   = 1'b0;
    bit         rand_pop  = 1'b0;
    bit         force_pop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    // reference: payload length from the header rule, result = XOR of payload bytes
    function automatic int plen(input logic [7:0] h);
        return h[7] ? 0 : int'(h[2:0]);
    endfunction

    function automatic logic [7:0] xor_all();
        logic [7:0] x = 8'h00;
        foreach (pay_buf[i]) x ^= pay_buf[i];
        return x;
    endfunction

    // called at a negedge; waits for space, drives one byte across the next posedge
    task automatic push_byte(input logic [7:0] b);
        int g = 0;
        while (!bus.ififo_not_full && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: ififo_not_full stuck at 0, required 1");
        end
        bus.ififo_push = 1'b1;
        bus.idata      = b;
        @(negedge clk);
        bus.ififo_push = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] h);
        exp_q.push_back(xor_all());
        push_byte(h);
        foreach (pay_buf[i]) push_byte(pay_buf[i]);
    endtask

    task automatic rand_pkt();
        logic [7:0] h;
        h = 8'($urandom_range(0, 255));
        pay_buf.delete();
        for (int i = 0; i < plen(h); i++) pay_buf.push_back(8'($urandom_range(0, 255)));
        send_pkt(h);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || bus.ofifo_rdy) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check(name, (exp_q.size() == 0 && !bus.ofifo_rdy) ? 1 : 0, 1);
    endtask

    // monitor: consume and compare each result the DUT presents
    initial begin
        bus.ofifo_pop = 1'b0;
        forever begin
            @(negedge clk);
            if (cons_en && bus.ofifo_rdy && (!rand_pop || $urandom_range(0, 3) != 0)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h, required no result", bus.odata);
                end else begin
                    check("result", bus.odata, exp_q.pop_front());
                end
                bus.ofifo_pop = 1'b1;
            end else begin
                bus.ofifo_pop = force_pop;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        pwr_on         = 1'b1;
        bus.ififo_push = 1'b0;
        bus.idata      = 8'h00;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_not_full", bus.ififo_not_full, 1);
        check("reset_rdy", bus.ofifo_rdy, 0);
        check("reset_odata", bus.odata, 0);

        // directed packet with latency check: header at t0, payload t1..t3
        pay_buf = '{8'h12, 8'h34, 8'h0F};
        send_pkt(8'h03);
        @(negedge clk);
        check("lat_before_write_rdy", bus.ofifo_rdy, 0);
        @(negedge clk);
        check("lat_after_write_rdy", bus.ofifo_rdy, 1);
        check("lat_odata", bus.odata, 8'h29);
        cons_en = 1'b1;
        repeat (3) @(negedge clk);
        check("single_result_rdy_low", bus.ofifo_rdy, 0);
        check("single_result_consumed", exp_q.size(), 0);
        check("empty_odata_zero", bus.odata, 0);

        // empty payloads, including a header with the top bit set
        pay_buf.delete();
        send_pkt(8'h00);
        send_pkt(8'hF9);
        wait_drain("drain_empty_pkts");

        // pop held on an empty FIFO must leave state untouched
        cons_en   = 1'b0;
        force_pop = 1'b1;
        repeat (3) @(negedge clk);
        force_pop = 1'b0;
        @(negedge clk);
        check("pop_empty_not_full", bus.ififo_not_full, 1);
        check("pop_empty_rdy", bus.ofifo_rdy, 0);
        check("pop_empty_odata", bus.odata, 0);
        cons_en = 1'b1;
        pay_buf = '{8'hAA};
        send_pkt(8'h01);
        wait_drain("drain_after_pop_empty");

        // fill: 8 results queued + 1 stalled in WR, then 16 bytes fill the input FIFO
        cons_en = 1'b0;
        for (int i = 0; i < 9; i++) rand_pkt();
        repeat (30) @(negedge clk);
        check("fill_ofifo_rdy", bus.ofifo_rdy, 1);
        check("fill_ififo_not_full_before", bus.ififo_not_full, 1);
        for (int i = 0; i < 4; i++) begin
            pay_buf.delete();
            for (int j = 0; j < 3; j++) pay_buf.push_back(8'($urandom_range(0, 255)));
            send_pkt(8'h03);
        end
        check("fill_ififo_full", bus.ififo_not_full, 0);
        bus.ififo_push = 1'b1;
        bus.idata      = 8'h05;
        @(negedge clk);
        bus.ififo_push = 1'b0;
        check("fill_still_full_after_drop", bus.ififo_not_full, 0);
        cons_en  = 1'b1;
        rand_pop = 1'b1;
        wait_drain("drain_after_fill");
        pay_buf = '{8'h0F, 8'hF0};
        send_pkt(8'h02);
        wait_drain("drain_post_fill_pkt");

        // randomized traffic with a randomly stalling consumer
        for (int i = 0; i < 40; i++) rand_pkt();
        wait_drain("drain_random");
        rand_pop = 1'b0;

`ifdef XOREXEC_PWR_ISO_EN
        // power loss mid-payload with a result already queued
        cons_en = 1'b0;
        pay_buf = '{8'h77};
        send_pkt(8'h01);
        for (int g = 0; g < 20 && !bus.ofifo_rdy; g++) @(negedge clk);
        check("pwr_pre_rdy", bus.ofifo_rdy, 1);
        push_byte(8'h03);
        push_byte(8'h11);
        pwr_on = 1'b0;
        #1;
        check("iso_not_full", bus.ififo_not_full, 0);
        check("iso_rdy", bus.ofifo_rdy, 0);
        check("iso_odata", bus.odata, 0);
        @(negedge clk);
        bus.ififo_push = 1'b1;
        bus.idata      = 8'h07;
        repeat (3) @(negedge clk);
        bus.ififo_push = 1'b0;
        exp_q.delete();
        pwr_on = 1'b1;
        @(negedge clk);
        check("pwr_up_not_full", bus.ififo_not_full, 1);
        check("pwr_up_rdy", bus.ofifo_rdy, 0);
        check("pwr_up_odata", bus.odata, 0);
        cons_en = 1'b1;
        pay_buf = '{8'h55, 8'hFF};
        send_pkt(8'h02);
        wait_drain("drain_after_power");
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
